mips_divider_param: RTL

//  Parametrised iterative integer divider for the MIPS CPU multiply/divide unit (DIV/DIVU).

---
 rtl/mips_divider_param.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mips_divider_param.sv
// mips_divider_param: iterative restoring divider for DIV/DIVU, retiring BITS_PER_CYCLE
// quotient bits per clock with start/busy/done handshake and divide-by-zero flag.
module mips_divider_param #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             signed_op_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o
);
   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, orig_q, orig_d;
   logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
   logic             neg_q, neg_d, dsn_q, dsn_d, busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
   logic [WIDTH-1:0] step_rem, step_dvd;
   logic [WIDTH:0]   trial;
   // dvd holds the unconsumed dividend bits on top and shifts quotient bits in at the bottom
   always_comb begin
      step_rem = rem_q;
      step_dvd = dvd_q;
      trial    = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         trial    = {step_rem, step_dvd[WIDTH-1]};
         step_dvd = {step_dvd[WIDTH-2:0], 1'b0};
         if (trial >= {1'b0, dvs_q}) begin
            trial       = trial - {1'b0, dvs_q};
            step_dvd[0] = 1'b1;
         end
         step_rem = trial[WIDTH-1:0];
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      orig_d  = orig_q;
      neg_d   = neg_q;
      dsn_d   = dsn_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE: if (start_i) begin
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = '0;
            busy_d  = 1'b1;
            neg_d   = signed_op_i & dividend_i[WIDTH-1];
            dsn_d   = signed_op_i & divisor_i[WIDTH-1];
            dvd_d   = neg_d ? -dividend_i : dividend_i;
            dvs_d   = dsn_d ? -divisor_i : divisor_i;
            orig_d  = dividend_i;
         end
         CALC: begin
            dvd_d   = step_dvd;
            rem_d   = step_rem;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(N - 1)) ? FIX : CALC;
         end
         FIX: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            dbz_d   = (dvs_q == '0);
            quo_d   = dbz_d ? '1 : (neg_q ^ dsn_q) ? -dvd_q : dvd_q;
            rmd_d   = dbz_d ? orig_q : neg_q ? -rem_q : rem_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         orig_q  <= '0;
         neg_q   <= 1'b0;
         dsn_q   <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         orig_q  <= orig_d;
         neg_q   <= neg_d;
         dsn_q   <= dsn_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end
   assign quotient_o    = quo_q;
   assign remainder_o   = rmd_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign div_by_zero_o = dbz_q;
endmodule
